// File: rtl/glitcbus_pkg.sv
// GLITCBUS initiator shared encodings and sizes.
// Imported by the master and its byte shifter.
package glitcbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADR0,
      ST_ADR1,
      ST_WDATA,
      ST_TURN,
      ST_WAIT,
      ST_RDATA,
      ST_GAP
   } gb_state_e;

   localparam int GB_BYTES     = 4;
   localparam int GB_ADR_BYTES = 2;
   localparam int GB_DAT_W     = 8 * GB_BYTES;
   localparam int GB_ADR_W     = 8 * GB_ADR_BYTES;
   localparam int GB_CNT_W     = $clog2(GB_BYTES);

endpackage

// File: rtl/glitcbus_byte_shifter.sv
// LSB-first byte shifter for the GLITCBUS data phase.
// Same right-shift serves write emission and read assembly.
module glitcbus_byte_shifter
   import glitcbus_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [GB_DAT_W-1:0] load_word,
   input  logic                shift,
   input  logic [7:0]          din,
   output logic [7:0]          byte0,
   output logic [7:0]          byte1,
   output logic [GB_DAT_W-1:0] word_next,
   output logic                done
);

   logic [GB_DAT_W-1:0] word;
   logic [GB_CNT_W-1:0] cnt;

   assign word_next = {din, word[GB_DAT_W-1:8]};
   assign byte0     = word[7:0];
   assign byte1     = word[15:8];
   assign done      = (cnt == GB_CNT_W'(GB_BYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word <= '0;
         cnt  <= '0;
      end else if (load) begin
         word <= load_word;
         cnt  <= '0;
      end else if (shift) begin
         word <= word_next;
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/glitcbus_master.sv
// GLITCBUS initiator: serialises 16-bit address / 32-bit data
// transfers onto the 8-bit multiplexed GAD bus.
module glitcbus_master
   import glitcbus_pkg::*;
#(
   parameter int READ_WAIT = 2
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                req_i,
   input  logic                wr_i,
   input  logic [GB_ADR_W-1:0] adr_i,
   input  logic [GB_DAT_W-1:0] dat_i,
   output logic [GB_DAT_W-1:0] dat_o,
   output logic                ack_o,
   output logic                busy_o,
   output logic                gsel_b_o,
   output logic                grdwr_b_o,
   output logic [7:0]          gad_o,
   output logic                gad_oe_o,
   input  logic [7:0]          gad_i
);

   localparam logic [3:0] WAIT_LD = 4'(READ_WAIT - 1);

   gb_state_e           st;
   logic                pend;
   logic                wr;
   logic [GB_ADR_W-1:0] adr;
   logic [3:0]          wcnt;
   logic                take;
   logic                shift;
   logic [7:0]          byte0;
   logic [7:0]          byte1;
   logic [GB_DAT_W-1:0] word_next;
   logic                done;

   // A request is taken in idle, or on the edge that closes the ack cycle.
   assign take  = req_i && (((st == ST_IDLE) && !pend) || (st == ST_GAP));
   assign shift = (st == ST_WDATA) || (st == ST_RDATA);

   glitcbus_byte_shifter u_shift (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .load      (take),
      .load_word (dat_i),
      .shift     (shift),
      .din       (gad_i),
      .byte0     (byte0),
      .byte1     (byte1),
      .word_next (word_next),
      .done      (done)
   );

   // Outputs are set on the edge entering a phase, so they match st.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st        <= ST_IDLE;
         pend      <= 1'b0;
         wr        <= 1'b0;
         adr       <= '0;
         wcnt      <= '0;
         gsel_b_o  <= 1'b1;
         grdwr_b_o <= 1'b1;
         gad_oe_o  <= 1'b0;
         gad_o     <= 8'h00;
         ack_o     <= 1'b0;
         dat_o     <= '0;
         busy_o    <= 1'b0;
      end else begin
         ack_o <= 1'b0;
         if (take) begin
            pend <= 1'b1;
            wr   <= wr_i;
            adr  <= adr_i;
         end
         unique case (st)
            ST_IDLE: begin
               if (pend) begin
                  pend      <= 1'b0;
                  st        <= ST_ADR0;
                  gsel_b_o  <= 1'b0;
                  grdwr_b_o <= ~wr;
                  gad_oe_o  <= 1'b1;
                  gad_o     <= adr[7:0];
               end else begin
                  busy_o <= take;
               end
            end
            ST_ADR0: begin
               st    <= ST_ADR1;
               gad_o <= adr[15:8];
            end
            ST_ADR1: begin
               if (wr) begin
                  st    <= ST_WDATA;
                  gad_o <= byte0;
               end else begin
                  st       <= ST_TURN;
                  gad_oe_o <= 1'b0;
                  gad_o    <= 8'h00;
               end
            end
            ST_WDATA: begin
               if (done) begin
                  st        <= ST_GAP;
                  gsel_b_o  <= 1'b1;
                  grdwr_b_o <= 1'b1;
                  gad_oe_o  <= 1'b0;
                  gad_o     <= 8'h00;
                  ack_o     <= 1'b1;
               end else begin
                  gad_o <= byte1;
               end
            end
            ST_TURN: begin
               if (READ_WAIT == 0) begin
                  st <= ST_RDATA;
               end else begin
                  st   <= ST_WAIT;
                  wcnt <= WAIT_LD;
               end
            end
            ST_WAIT: begin
               if (wcnt == 4'd0) st <= ST_RDATA;
               else              wcnt <= wcnt - 4'd1;
            end
            ST_RDATA: begin
               if (done) begin
                  st        <= ST_GAP;
                  gsel_b_o  <= 1'b1;
                  grdwr_b_o <= 1'b1;
                  ack_o     <= 1'b1;
                  dat_o     <= word_next;
               end
            end
            ST_GAP: begin
               st     <= ST_IDLE;
               busy_o <= take;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

endmodule
